// File: rtl/reg_dump.sv
// Register-file dump engine: walks every entry through one asynchronous read
// port and streams each value out over valid/ready, tagged with its index.
module reg_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int SKIP_ZERO  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? ADDR_WIDTH'(1) : '0;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] idx;

  assign rf_read_addr = idx;
  assign busy         = (state == FETCH) || (state == SEND);
  assign done         = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort outranks both a fresh start and a pending handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        next_state = abort ? IDLE : SEND;
      end
      SEND: begin
        if (abort) begin
          next_state = IDLE;
        end else if (out_ready) begin
          next_state = (idx == LAST_IDX) ? DONE : FETCH;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            idx <= FIRST_IDX;
          end
        end
        FETCH: begin
          if (abort) begin
            idx       <= '0;
            out_valid <= 1'b0;
          end else begin
            out_data  <= rf_read_data;
            out_index <= idx;
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            idx       <= '0;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            // The last entry parks idx so the walk can never wrap around.
            if (idx != LAST_IDX) begin
              idx <= idx + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          idx <= '0;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: two instances (SKIP_ZERO 0 and 1) share a
// behavioural register file; transfers are compared against an ordered model.
module tb_reg_dump;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic reset, start, abort, out_ready, sel;
  logic [DW-1:0] rf [N];

  logic          busy0, done0, valid0, busy1, done1, valid1;
  logic [AW-1:0] addr0, index0, addr1, index1;
  logic [DW-1:0] data0, rd0, data1, rd1;
  logic          start0, start1;

  logic          busy, done, valid;
  logic [AW-1:0] addr, index;
  logic [DW-1:0] data;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign rd0    = rf[addr0];
  assign rd1    = rf[addr1];
  assign busy   = sel ? busy1  : busy0;
  assign done   = sel ? done1  : done0;
  assign valid  = sel ? valid1 : valid0;
  assign addr   = sel ? addr1  : addr0;
  assign index  = sel ? index1 : index0;
  assign data   = sel ? data1  : data0;

  reg_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort), .busy(busy0), .done(done0),
    .rf_read_addr(addr0), .rf_read_data(rd0), .out_valid(valid0), .out_ready(out_ready),
    .out_data(data0), .out_index(index0)
  );

  reg_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort), .busy(busy1), .done(done1),
    .rf_read_addr(addr1), .rf_read_data(rd1), .out_valid(valid1), .out_ready(out_ready),
    .out_data(data1), .out_index(index1)
  );

  int checks = 0;
  int errors = 0;

  int stall_idx, abort_after;
  bit rand_ready, wr_test, start_noise;
  int done_cycle, done_cnt;
  int got_idx[$];
  logic [DW-1:0] got_data[$];
  int exp_idx[$];
  logic [DW-1:0] exp_data[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < N; i++) rf[i] = '0;
    rf[1]  = 32'h0000_0011;
    rf[10] = 32'hA0A0_A0A0;
    rf[31] = 32'hDEAD_BEEF;
  endtask

  // Reference: an uninterrupted dump emits every index from the first one up
  // to the last, each carrying the register contents at the time it is read.
  task automatic buildExpected(input bit skip);
    exp_idx.delete();
    exp_data.delete();
    for (int i = (skip ? 1 : 0); i < N; i++) begin
      exp_idx.push_back(i);
      exp_data.push_back(rf[i]);
    end
  endtask

  task automatic verifyDump(input string tag, input int n);
    checkOutput($sformatf("%s_count", tag), got_idx.size(), n);
    for (int i = 0; i < n && i < got_idx.size(); i++) begin
      checkOutput($sformatf("%s_idx%0d", tag, i), got_idx[i], exp_idx[i]);
      checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
  endtask

  task automatic applyStimulus(input bit skip);
    int  c = 0;
    int  stall_left = 5;
    int  stall_hs = -1;
    bit  next_seen = 0;
    int  hs_cycle = -1;
    bit  just_aborted = 0;
    int  post = -1;
    sel = skip;
    got_idx.delete();
    got_data.delete();
    done_cnt   = 0;
    done_cycle = -1;
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    while (c < 1000 && post != 0) begin
      if (post > 0) post--;
      abort     = 1'b0;
      start     = 1'b0;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (start_noise && busy && $urandom_range(0, 2) == 0) start = 1'b1;
      if (valid && int'(index) == stall_idx && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        checkOutput("stall_valid", valid, 1);
        checkOutput("stall_data", data, 32'hA0A0_A0A0);
        checkOutput("stall_addr", addr, stall_idx);
      end
      if (valid && stall_hs >= 0 && int'(index) == stall_idx + 1 && !next_seen) begin
        next_seen = 1;
        checkOutput("stall_next_gap", c + 1 - stall_hs, 2);
      end
      if (hs_cycle == c) begin
        abort = 1'b1;
        hs_cycle = -1;
        just_aborted = 1;
        post = 4;
      end
      if (valid && out_ready) begin
        got_idx.push_back(int'(index));
        got_data.push_back(data);
        if (int'(index) == abort_after) hs_cycle = c + 1;
        if (int'(index) == stall_idx) stall_hs = c + 1;
        if (wr_test && index == 5'd5) rf[20] = 32'h0000_0055;
        if (wr_test && index == 5'd3) rf[3] = 32'h0000_BAD3;
      end
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c + 1;
        if (post < 0) post = 3;
      end
      step();
      c++;
      if (just_aborted) begin
        just_aborted = 0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", valid, 0);
      end
    end
    abort     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    checkOutput("run_terminated", post == 0, 1);
    checkOutput("idle_busy", busy, 0);
  endtask

  initial begin
    int  w;
    bit  skip;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; sel = 1'b0;
    stall_idx = -1; abort_after = -1; rand_ready = 0; wr_test = 0; start_noise = 0;
    preload();
    #12;
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_valid", valid0, 0);
    checkOutput("rst_addr", addr0, 0);
    checkOutput("rst_data", data0, 0);
    checkOutput("rst_index", index0, 0);
    checkOutput("rst_addr1", addr1, 0);
    #3 reset = 1'b0;
    step();

    $display("[TB] full dump, SKIP_ZERO=0, start pulses while busy");
    preload();
    buildExpected(0);
    start_noise = 1;
    applyStimulus(0);
    start_noise = 0;
    verifyDump("full0", 32);
    checkOutput("full0_done_cycle", done_cycle, 65);
    checkOutput("full0_done_cnt", done_cnt, 1);
    if (got_data.size() == 32) begin
      checkOutput("full0_x10", got_data[10], 32'hA0A0_A0A0);
      checkOutput("full0_x31", got_data[31], 32'hDEAD_BEEF);
    end

    $display("[TB] full dump, SKIP_ZERO=1");
    buildExpected(1);
    applyStimulus(1);
    verifyDump("full1", 31);
    checkOutput("full1_done_cycle", done_cycle, 63);
    checkOutput("full1_done_cnt", done_cnt, 1);
    if (got_idx.size() > 0) begin
      checkOutput("full1_first_idx", got_idx[0], 1);
      checkOutput("full1_first_data", got_data[0], 32'h11);
    end

    $display("[TB] back-pressure at index 10");
    buildExpected(0);
    stall_idx = 10;
    applyStimulus(0);
    stall_idx = -1;
    verifyDump("stall", 32);
    checkOutput("stall_done_cnt", done_cnt, 1);

    $display("[TB] abort in FETCH of index 5, then restart");
    buildExpected(0);
    abort_after = 4;
    applyStimulus(0);
    abort_after = -1;
    verifyDump("abort", 5);
    checkOutput("abort_done_cnt", done_cnt, 0);
    applyStimulus(0);
    verifyDump("restart", 32);
    checkOutput("restart_done_cnt", done_cnt, 1);

    $display("[TB] asynchronous reset mid-SEND");
    sel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (w < 100 && !(valid && index == 5'd7)) begin
      out_ready = 1'b1;
      step();
      w++;
      if (valid && index == 5'd7) out_ready = 1'b0;
    end
    checkOutput("arst_reached", w < 100, 1);
    checkOutput("arst_pre_addr", addr, 7);
    checkOutput("arst_pre_valid", valid, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_valid", valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_addr", addr, 0);
    checkOutput("arst_data", data, 0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("arst_idle", busy, 0);

    $display("[TB] register writes during the dump");
    preload();
    rf[3] = 32'h0000_0303;
    buildExpected(0);
    exp_data[20] = 32'h0000_0055;
    wr_test = 1;
    applyStimulus(0);
    wr_test = 0;
    verifyDump("wr", 32);

    $display("[TB] randomized dumps with random back-pressure");
    rand_ready = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) rf[i] = $urandom;
      skip = 1'($urandom_range(0, 1));
      buildExpected(skip);
      applyStimulus(skip);
      verifyDump($sformatf("rnd%0d", r), skip ? 31 : 32);
      checkOutput($sformatf("rnd%0d_done_cnt", r), done_cnt, 1);
    end
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
- Debug/verification reader for the 32-entry register file.
- On a start pulse, walks the register file through one asynchronous read port (address out, data back the same cycle) and streams each register value out over a valid/ready handshake, tagged with its index.
- Sits beside the core's register file on a spare read port; consumed by the testbench/trace logic or a UART debug bridge.

Parameters:
- DATA_WIDTH, 32, width of each register and of out_data.
- ADDR_WIDTH, 5, register index width; the dump covers 2**ADDR_WIDTH entries.
- SKIP_ZERO, 0, when 1 the walk starts at index 1 (x0 is not emitted).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE immediately.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  terminates an in-progress dump.
- busy  output  1  high in FETCH and SEND.
- done  output  1  one-cycle pulse after the last register is accepted.
- rf_read_addr  output  ADDR_WIDTH  read address to the register file.
- rf_read_data  input  DATA_WIDTH  combinational read data for rf_read_addr.
- out_valid  output  1  out_data/out_index hold a register value.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_data  output  DATA_WIDTH  captured register value.
- out_index  output  ADDR_WIDTH  register index of out_data.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, rf_read_addr=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0.
- rf_read_addr is driven directly from the idx register (registered, glitch-free).
- States: IDLE, FETCH, SEND, DONE.
- IDLE: start=1 -> idx<=(SKIP_ZERO ? 1 : 0), go FETCH. A start arriving when not in IDLE is ignored (no queueing).
- FETCH (1 cycle): out_data<=rf_read_data, out_index<=idx, out_valid<=1, go SEND.
- SEND:
  - out_valid=1; out_data/out_index held stable until accepted.
  - On handshake: out_valid<=0. If idx==2**ADDR_WIDTH-1, go DONE; else idx<=idx+1, go FETCH.
  - Index comparison is at full width; idx never wraps past the last entry.
- DONE: done=1 for exactly one cycle, then IDLE; idx<=0.
- Throughput: 2 cycles per register with out_ready held high.
- Latency: start to first out_valid is 2 cycles (start edge -> FETCH, FETCH edge -> valid).
- Full dump with out_ready=1:
  - SKIP_ZERO=0: 32 transfers, done asserted on cycle 65 after the start edge.
  - SKIP_ZERO=1: 31 transfers, done on cycle 63.
- abort: in FETCH or SEND -> IDLE next edge; out_valid<=0, idx<=0, no done pulse. abort in IDLE or DONE has no effect. abort together with a SEND handshake: the transfer counts as accepted, then IDLE.
- start together with abort in IDLE: abort wins, stay IDLE.
- No snapshot: a value is sampled in its FETCH cycle. A write-back to a register that has not yet been fetched is visible in the dump; a write to one already fetched is not.
- Back-pressure: out_ready may stay low indefinitely; the block holds SEND with stable outputs and no timeout.

Test Plan:
- Preload x1=0x11, x10=0xA0A0A0A0, x31=0xDEADBEEF, others 0; start with out_ready=1, SKIP_ZERO=0 -> 32 transfers with out_index 0..31 in order, index 10 carries 0xA0A0A0A0, index 31 carries 0xDEADBEEF, done pulses once on cycle 65, busy low afterwards.
- SKIP_ZERO=1, same preload -> first transfer out_index=1, out_data=0x11; 31 transfers total; done on cycle 63.
- Back-pressure: hold out_ready=0 for 5 cycles during index 10's SEND -> out_valid stays 1, out_data stays 0xA0A0A0A0, rf_read_addr stays 10; release -> index 11 follows 2 cycles later.
- Abort after the index-4 handshake (in FETCH of index 5) -> next cycle busy=0, out_valid=0, no done; a new start restarts at index 0.
- Assert reset asynchronously mid-SEND (no clock edge) -> out_valid, busy and rf_read_addr drop to 0 immediately; start pulses during busy are ignored (exactly one dump of 32 occurs).
- Core writes x20=0x55 during the dump before index 20 is fetched -> dump shows 0x55 at index 20; a write to x3 after index 3 is fetched -> dump shows the old x3 value.
